// File: rtl/npc.sv
// Next-PC unit: selects the successor fetch address and keeps a registered PC copy.
// Latency: next_pc/link_pc are combinational (0 cycles); pc_q updates 1 cycle after next_pc.
// Backpressure: en=0 stalls pc_q (holds its value); there is no handshake.
module npc #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] ISR_ADDR = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [31:0] curr_pc,
    input  logic [3:0]  jump_mode,
    input  logic [1:0]  cmp_result,
    input  logic [1:0]  cmp_sig_result,
    input  logic [15:0] num,
    input  logic [25:0] jnum,
    input  logic [31:0] reg_,
    input  logic [31:0] epc,
    output logic [31:0] next_pc,
    output logic [31:0] link_pc,
    output logic [31:0] pc_q
);

    typedef enum logic [3:0] {
        JM_DISABLED       = 4'd0,
        JM_WHEN_EQUAL     = 4'd1,
        JM_WHEN_NOT_EQUAL = 4'd2,
        JM_GEZ            = 4'd3,
        JM_GTZ            = 4'd4,
        JM_LTZ            = 4'd5,
        JM_LEZ            = 4'd6,
        JM_JNUM           = 4'd7,
        JM_REG            = 4'd8,
        JM_ISR            = 4'd9,
        JM_EPC            = 4'd10
    } jump_mode_t;

    localparam logic [1:0] CMP_EQ = 2'b00;
    localparam logic [1:0] CMP_GT = 2'b01;
    localparam logic [1:0] CMP_LT = 2'b10;

    logic [31:0] seq_pc;
    logic [31:0] br_pc;
    logic [31:0] jt_pc;
    logic        taken;

    assign seq_pc  = curr_pc + 32'd4;
    assign br_pc   = seq_pc + {{14{num[15]}}, num, 2'b00};
    assign jt_pc   = {curr_pc[31:28], jnum, 2'b00};
    assign link_pc = curr_pc + 32'd8;

    // Compare code 11 (invalid) matches none of the taken conditions below.
    always_comb begin
        taken = 1'b0;
        case (jump_mode)
            JM_WHEN_EQUAL:     taken = (cmp_result == CMP_EQ);
            JM_WHEN_NOT_EQUAL: taken = (cmp_result == CMP_GT) || (cmp_result == CMP_LT);
            JM_GEZ:            taken = (cmp_sig_result == CMP_EQ) || (cmp_sig_result == CMP_GT);
            JM_GTZ:            taken = (cmp_sig_result == CMP_GT);
            JM_LTZ:            taken = (cmp_sig_result == CMP_LT);
            JM_LEZ:            taken = (cmp_sig_result == CMP_EQ) || (cmp_sig_result == CMP_LT);
            default:           taken = 1'b0;
        endcase
    end

    always_comb begin
        next_pc = seq_pc;
        case (jump_mode)
            JM_WHEN_EQUAL, JM_WHEN_NOT_EQUAL,
            JM_GEZ, JM_GTZ, JM_LTZ, JM_LEZ: next_pc = taken ? br_pc : seq_pc;
            JM_JNUM:                        next_pc = jt_pc;
            JM_REG:                         next_pc = reg_;
            JM_ISR:                         next_pc = ISR_ADDR;
            JM_EPC:                         next_pc = epc;
            default:                        next_pc = seq_pc;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else if (en) begin
            pc_q <= next_pc;
        end
    end

endmodule

// File: tb/tb_npc.sv
// Directed bench for npc: a vector table for the combinational paths plus
// hand-written sequences for reset, stall and wraparound of pc_q.
module tb_npc;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [31:0] curr_pc;
    logic [3:0]  jump_mode;
    logic [1:0]  cmp_result;
    logic [1:0]  cmp_sig_result;
    logic [15:0] num;
    logic [25:0] jnum;
    logic [31:0] reg_;
    logic [31:0] epc;
    logic [31:0] next_pc;
    logic [31:0] link_pc;
    logic [31:0] pc_q;

    int n_checks = 0;
    int n_fails  = 0;

    npc dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .en             (en),
        .curr_pc        (curr_pc),
        .jump_mode      (jump_mode),
        .cmp_result     (cmp_result),
        .cmp_sig_result (cmp_sig_result),
        .num            (num),
        .jnum           (jnum),
        .reg_           (reg_),
        .epc            (epc),
        .next_pc        (next_pc),
        .link_pc        (link_pc),
        .pc_q           (pc_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [3:0]  mode;
        logic [1:0]  cmp;
        logic [1:0]  sig;
        logic [15:0] imm;
        logic [25:0] jidx;
        logic [31:0] rg;
        logic [31:0] ep;
        logic [31:0] exp_next;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input string name, input logic [31:0] pc, input logic [3:0] mode,
                       input logic [1:0] cmp, input logic [1:0] sig, input logic [15:0] imm,
                       input logic [25:0] jidx, input logic [31:0] rg, input logic [31:0] ep,
                       input logic [31:0] exp_next);
        vec_t v;
        v.name = name; v.pc = pc; v.mode = mode; v.cmp = cmp; v.sig = sig;
        v.imm = imm; v.jidx = jidx; v.rg = rg; v.ep = ep; v.exp_next = exp_next;
        vecs.push_back(v);
    endtask

    initial begin
        // Distractor operands so a wrong select shows up as a wrong address.
        automatic logic [31:0] rg_d = 32'hDEAD_BEE0;
        automatic logic [31:0] ep_d = 32'hCAFE_F00C;
        automatic logic [25:0] jn_d = 26'h3FF_FFFF;

        add("seq",         32'h4, 4'd0, 2'b00, 2'b00, 16'h0008, jn_d, rg_d, ep_d, 32'h8);
        add("beq_taken",   32'h4, 4'd1, 2'b00, 2'b01, 16'h0008, jn_d, rg_d, ep_d, 32'h28);
        add("beq_back",    32'h4, 4'd1, 2'b00, 2'b01, 16'hFFFF, jn_d, rg_d, ep_d, 32'h4);
        add("beq_nt",      32'h4, 4'd1, 2'b01, 2'b00, 16'hFFFF, jn_d, rg_d, ep_d, 32'h8);
        add("beq_inv",     32'h4, 4'd1, 2'b11, 2'b00, 16'h0008, jn_d, rg_d, ep_d, 32'h8);
        add("bne_gt",      32'h4, 4'd2, 2'b01, 2'b00, 16'h0008, jn_d, rg_d, ep_d, 32'h28);
        add("bne_lt",      32'h4, 4'd2, 2'b10, 2'b00, 16'h0008, jn_d, rg_d, ep_d, 32'h28);
        add("bne_eq",      32'h4, 4'd2, 2'b00, 2'b01, 16'h0008, jn_d, rg_d, ep_d, 32'h8);
        add("bne_inv",     32'h4, 4'd2, 2'b11, 2'b01, 16'h0008, jn_d, rg_d, ep_d, 32'h8);
        add("bgez_00",     32'h3000, 4'd3, 2'b11, 2'b00, 16'h0010, jn_d, rg_d, ep_d, 32'h3044);
        add("bgez_01",     32'h3000, 4'd3, 2'b11, 2'b01, 16'h0010, jn_d, rg_d, ep_d, 32'h3044);
        add("bgez_10",     32'h3000, 4'd3, 2'b00, 2'b10, 16'h0010, jn_d, rg_d, ep_d, 32'h3004);
        add("bgez_11",     32'h3000, 4'd3, 2'b00, 2'b11, 16'h0010, jn_d, rg_d, ep_d, 32'h3004);
        add("bgtz_00",     32'h3000, 4'd4, 2'b00, 2'b00, 16'h0010, jn_d, rg_d, ep_d, 32'h3004);
        add("bgtz_01",     32'h3000, 4'd4, 2'b00, 2'b01, 16'h0010, jn_d, rg_d, ep_d, 32'h3044);
        add("bgtz_10",     32'h3000, 4'd4, 2'b00, 2'b10, 16'h0010, jn_d, rg_d, ep_d, 32'h3004);
        add("bgtz_11",     32'h3000, 4'd4, 2'b00, 2'b11, 16'h0010, jn_d, rg_d, ep_d, 32'h3004);
        add("bltz_00",     32'h3000, 4'd5, 2'b00, 2'b00, 16'h0010, jn_d, rg_d, ep_d, 32'h3004);
        add("bltz_01",     32'h3000, 4'd5, 2'b00, 2'b01, 16'h0010, jn_d, rg_d, ep_d, 32'h3004);
        add("bltz_10",     32'h3000, 4'd5, 2'b00, 2'b10, 16'h0010, jn_d, rg_d, ep_d, 32'h3044);
        add("bltz_11",     32'h3000, 4'd5, 2'b00, 2'b11, 16'h0010, jn_d, rg_d, ep_d, 32'h3004);
        add("blez_00",     32'h3000, 4'd6, 2'b01, 2'b00, 16'h0010, jn_d, rg_d, ep_d, 32'h3044);
        add("blez_01",     32'h3000, 4'd6, 2'b00, 2'b01, 16'h0010, jn_d, rg_d, ep_d, 32'h3004);
        add("blez_10",     32'h3000, 4'd6, 2'b01, 2'b10, 16'h0010, jn_d, rg_d, ep_d, 32'h3044);
        add("blez_11",     32'h3000, 4'd6, 2'b00, 2'b11, 16'h0010, jn_d, rg_d, ep_d, 32'h3004);
        add("j",           32'h9000_0000, 4'd7, 2'b00, 2'b00, 16'h0008, 26'h0000C01, rg_d, ep_d, 32'h9000_3004);
        add("jr",          32'h4, 4'd8, 2'b00, 2'b00, 16'h0008, jn_d, 32'h1234_5678, ep_d, 32'h1234_5678);
        add("jr_unalign",  32'h4, 4'd8, 2'b00, 2'b00, 16'h0008, jn_d, 32'h1234_5679, ep_d, 32'h1234_5679);
        add("isr",         32'h4, 4'd9, 2'b00, 2'b00, 16'h0008, jn_d, rg_d, 32'h4000, 32'h4180);
        add("eret",        32'h8, 4'd10, 2'b00, 2'b00, 16'h0008, jn_d, rg_d, 32'h3004, 32'h3004);
        add("rsv_11",      32'h4, 4'd11, 2'b00, 2'b00, 16'h0008, jn_d, rg_d, ep_d, 32'h8);
        add("rsv_12",      32'h100, 4'd12, 2'b00, 2'b00, 16'h0008, jn_d, rg_d, ep_d, 32'h104);
        add("rsv_15",      32'h4, 4'd15, 2'b00, 2'b00, 16'h0008, jn_d, rg_d, ep_d, 32'h8);
        add("seq_wrap",    32'hFFFF_FFFC, 4'd0, 2'b00, 2'b00, 16'h0008, jn_d, rg_d, ep_d, 32'h0);
        add("beq_wrap",    32'hFFFF_FFF8, 4'd1, 2'b00, 2'b00, 16'h0002, jn_d, rg_d, ep_d, 32'h4);

        rst_n = 1'b1; en = 1'b0; curr_pc = '0; jump_mode = '0; cmp_result = '0;
        cmp_sig_result = '0; num = '0; jnum = '0; reg_ = '0; epc = '0;

        // Asynchronous reset well before the first rising edge at t=5.
        #1 rst_n = 1'b0;
        #1 check("async_reset", pc_q, 32'h3000);

        // Table runs with reset held and en=1: pc_q must not move.
        en = 1'b1;
        foreach (vecs[i]) begin
            curr_pc = vecs[i].pc; jump_mode = vecs[i].mode; cmp_result = vecs[i].cmp;
            cmp_sig_result = vecs[i].sig; num = vecs[i].imm; jnum = vecs[i].jidx;
            reg_ = vecs[i].rg; epc = vecs[i].ep;
            #3;
            check({vecs[i].name, "_next"}, next_pc, vecs[i].exp_next);
            check({vecs[i].name, "_link"}, link_pc, vecs[i].pc + 32'd8);
        end
        @(posedge clk); #1;
        check("reset_held", pc_q, 32'h3000);

        // Release mid-cycle: no change until the next rising edge.
        @(negedge clk);
        jump_mode = 4'd0; curr_pc = 32'h3000; en = 1'b1;
        #2 rst_n = 1'b1;
        #1 check("release_no_edge", pc_q, 32'h3000);
        @(posedge clk); #1;
        check("run_1", pc_q, 32'h3004);
        curr_pc = 32'h3004;
        @(posedge clk); #1;
        check("run_2", pc_q, 32'h3008);

        en = 1'b0; curr_pc = 32'h3008;
        @(posedge clk); #1;
        check("stall_1", pc_q, 32'h3008);
        @(posedge clk); #1;
        check("stall_2", pc_q, 32'h3008);

        // Reset asserted mid-cycle takes effect without a clock edge.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("mid_reset", pc_q, 32'h3000);
        en = 1'b1;
        @(posedge clk); #1;
        check("mid_reset_hold", pc_q, 32'h3000);

        @(negedge clk);
        rst_n = 1'b1; curr_pc = 32'hFFFF_FFFC; jump_mode = 4'd0; en = 1'b1;
        @(posedge clk); #1;
        check("pc_q_wrap", pc_q, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
